jt10_mix_sched: RTL and testbench
=================================

# jt10_mix_sched

Slot sequencer and ADPCM sample scheduler for the YM2610 output accumulator. Generates the 24-slot FM operator timing (`cur_ch`, `cur_op`, `s1..s4_enters`, `zero`) that drives the left/right accumulators. Receives ADPCM-A and ADPCM-B stereo samples from their decoders through valid/ready handshakes. Holds those samples stable for a whole accumulation frame, so the injections at slots {op0,ch2} and {op0,ch6} see frame-coherent data.

## Interface
- `W`, default 16: ADPCM sample width, signed.
- `UCNT_W`, default 8: underrun counter width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `clk_en`  in  1  slot advance enable.
- `mixA_en`, `mixB_en`  in  1  stream enable; when 0, the held output for that stream reads 0.
- `adpcmA_l_in`, `adpcmA_r_in`  in  W  ADPCM-A sample.
- `adpcmA_valid`  in  1;  `adpcmA_ready`  out  1.
- `adpcmB_l_in`, `adpcmB_r_in`  in  W  ADPCM-B sample.
- `adpcmB_valid`  in  1;  `adpcmB_ready`  out  1.
- `cur_ch`  out  3  channel code, sequence 0,1,2,4,5,6.
- `cur_op`  out  2  operator group index 0..3.
- `s1_enters`, `s2_enters`, `s3_enters`, `s4_enters`  out  1  one-hot operator strobe.
- `zero`  out  1  frame start; accumulator restarts.
- `adpcmA_l`, `adpcmA_r`, `adpcmB_l`, `adpcmB_r`  out  W  frame-held samples.
- `frame_done`  out  1  one-cycle pulse; accumulator outputs are new.
- `underrun_a`, `underrun_b`  out  UCNT_W  saturating count of frames with no fresh sample.

## Operation
- Slot counter `slot` runs 0..23 and advances on `clk_en`. After 23 it wraps to 0.
- Decode: `grp = slot/6`, `idx = slot%6`.
  - `cur_ch = {0,1,2,4,5,6}[idx]`.
  - `cur_op = grp`.
- Operator order by group is S1, S3, S2, S4. The strobe is therefore `s1_enters` for grp 0, `s3_enters` for grp 1, `s2_enters` for grp 2, `s4_enters` for grp 3.
- `zero = (slot==0)`.
- Frame event `F = clk_en & (slot==23)`.
- Each stream (A, B) has a pending register with a `full` flag, plus an active register.
- Handshake:
  - `ready = ~full | F`.
  - Transfer on `valid & ready` on any clk, independent of `clk_en`.
- On `F`, per stream:
  - full: active ← pending. If `valid & ready` in the same cycle, pending ← input and `full` stays 1; otherwise `full` ← 0.
  - not full, `valid` high: active ← input directly (bypass); `full` stays 0; no underrun.
  - not full, `valid` low: active keeps its value (repeat) and the underrun counter increments, saturating at all-ones.
- Not `F`, `valid & ready`: pending ← input, `full` ← 1.
- Held outputs: `adpcmX_* = mixX_en ? activeX_* : 0`. This gating is combinational on the registered active value.
- `frame_done` is registered and equals `F` delayed by one clk.

## Timing
- Reset (`rst_n` = 0 at a clk edge) sets:
  - `slot` = 0, so the outputs read `cur_ch` = 0, `cur_op` = 0, `s1_enters` = 1, other strobes 0, `zero` = 1.
  - active = 0, `full` = 0, both ready = 1.
  - underrun counters = 0, `frame_done` = 0.
- Reset mid-frame discards pending and active samples. No `frame_done` is emitted.
- Slot outputs are decoded from registered `slot` and change one clk after the `clk_en` edge.
- Active registers change only at the edge ending slot 23. They are stable from slot 0 through 23, including injection slots 2 (ch2, op0) and 5 (ch6, op0).
- Latency from sample acceptance to held output is at most one frame plus one clk. With bypass at `F` it is exactly one clk.
- `clk_en` held low freezes the slot counter. Handshakes still complete while pending is empty, and at most one sample per stream is buffered.

## Structure
- Shared package `jt10_mix_pkg`:
  - `SLOTS = 24`.
  - channel code table {0,1,2,4,5,6}.
  - operator order table S1, S3, S2, S4.
  - `ADPCMA_SLOT = 2`, `ADPCMB_SLOT = 5`.
- Sub-module `jt10_sample_hold`, instantiated twice (A, B): pending/active registers, `full` flag, ready logic, underrun counter. The top level contains the slot counter and decode.

## Test plan
- Reset, then `clk_en` held at 1 for 48 clk → `cur_ch` follows 0,1,2,4,5,6 repeated; strobes follow S1×6, S3×6, S2×6, S4×6; `zero` high at slots 0 and 24; `frame_done` high 1 clk after each slot 23.
- Push A = (0x1234, 0xEDCC) mid-frame → `adpcmA_ready` goes to 0. At the next frame boundary `adpcmA_l` = 0x1234 and `adpcmA_r` = 0xEDCC, and `ready` returns to 1.
- `adpcmB_valid` held at 0 for 3 frames after one sample → B output repeats that sample and `underrun_b` = 3. Then hold `valid` low for 300 frames → `underrun_b` saturates at 255.
- Pending full with `valid` asserted exactly on `F` (value 0x0101, then 0x0202) → active = 0x0101, pending = 0x0202, `full` = 1, no underrun.
- Empty pending with `valid` asserted on `F` (value 0x7FFF) → bypass: active = 0x7FFF one clk later, `underrun_a` unchanged. `mixA_en` = 0 → output reads 0.
- `rst_n` asserted at slot 13 with pending full → next cycle `slot` = 0, `zero` = 1, all held outputs 0, ready = 1.

Source files
------------

// File: rtl/jt10_mix_pkg.sv
// Shared constants and decode tables for the YM2610 mixer slot sequencer.
package jt10_mix_pkg;

  localparam int unsigned SLOTS       = 24;
  localparam int unsigned CH_PER_GRP  = 6;
  // Slots (within operator group 0) where ADPCM-A and ADPCM-B are injected
  localparam int unsigned ADPCMA_SLOT = 2;
  localparam int unsigned ADPCMB_SLOT = 5;

  typedef enum logic [1:0] {OpS1, OpS2, OpS3, OpS4} op_e;

  // Channel code for slot index within a group; code 3 is skipped
  function automatic logic [2:0] ch_code(input logic [2:0] idx);
    logic [2:0] code;
    code = 3'd0;
    unique case (idx)
      3'd0:    code = 3'd0;
      3'd1:    code = 3'd1;
      3'd2:    code = 3'd2;
      3'd3:    code = 3'd4;
      3'd4:    code = 3'd5;
      3'd5:    code = 3'd6;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Operator served by each group: S1, S3, S2, S4
  function automatic op_e op_order(input logic [1:0] grp);
    op_e op;
    op = OpS1;
    unique case (grp)
      2'd0: op = OpS1;
      2'd1: op = OpS3;
      2'd2: op = OpS2;
      2'd3: op = OpS4;
      default: op = OpS1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/jt10_sample_hold.sv
// Per-stream ADPCM sample buffer: one pending slot, one frame-held active sample,
// valid/ready intake and a saturating underrun counter.
module jt10_sample_hold #(
  parameter int unsigned W      = 16,
  parameter int unsigned UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              mix_en,
  input  logic [W-1:0]      l_in,
  input  logic [W-1:0]      r_in,
  input  logic              valid,
  output logic              ready,
  output logic [W-1:0]      l,
  output logic [W-1:0]      r,
  output logic [UCNT_W-1:0] underrun
);

  logic [W-1:0]      pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [W-1:0]      act_l_q, act_l_d, act_r_q, act_r_d;
  logic              full_q, full_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic              xfer;

  // Pending slot frees up on the frame edge, so a sample can arrive exactly then
  assign ready = ~full_q | frame;
  assign xfer  = valid & ready;

  // Next-state: promote/bypass/repeat on frame edge, otherwise buffer into pending
  always_comb begin
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    full_d   = full_q;
    ucnt_d   = ucnt_q;
    if (frame) begin
      if (full_q) begin
        act_l_d = pend_l_q;
        act_r_d = pend_r_q;
        full_d  = xfer;
        if (xfer) begin
          pend_l_d = l_in;
          pend_r_d = r_in;
        end
      end else if (valid) begin
        act_l_d = l_in;
        act_r_d = r_in;
      end else if (ucnt_q != {UCNT_W{1'b1}}) begin
        ucnt_d = ucnt_q + 1'b1;
      end
    end else if (xfer) begin
      pend_l_d = l_in;
      pend_r_d = r_in;
      full_d   = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_l_q <= '0;
      pend_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
      full_q   <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      full_q   <= full_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign l        = mix_en ? act_l_q : '0;
  assign r        = mix_en ? act_r_q : '0;
  assign underrun = ucnt_q;

endmodule

// File: rtl/jt10_mix_sched.sv
// Slot sequencer for the YM2610 output accumulator plus frame-coherent
// ADPCM-A/B sample scheduling.
module jt10_mix_sched
  import jt10_mix_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              mixA_en,
  input  logic              mixB_en,
  input  logic [W-1:0]      adpcmA_l_in,
  input  logic [W-1:0]      adpcmA_r_in,
  input  logic              adpcmA_valid,
  output logic              adpcmA_ready,
  input  logic [W-1:0]      adpcmB_l_in,
  input  logic [W-1:0]      adpcmB_r_in,
  input  logic              adpcmB_valid,
  output logic              adpcmB_ready,
  output logic [2:0]        cur_ch,
  output logic [1:0]        cur_op,
  output logic              s1_enters,
  output logic              s2_enters,
  output logic              s3_enters,
  output logic              s4_enters,
  output logic              zero,
  output logic [W-1:0]      adpcmA_l,
  output logic [W-1:0]      adpcmA_r,
  output logic [W-1:0]      adpcmB_l,
  output logic [W-1:0]      adpcmB_r,
  output logic              frame_done,
  output logic [UCNT_W-1:0] underrun_a,
  output logic [UCNT_W-1:0] underrun_b
);

  // Injection points must sit in operator group 0 so held samples are seen once per frame
  if (ADPCMA_SLOT >= CH_PER_GRP || ADPCMB_SLOT >= CH_PER_GRP) begin : g_bad_inject
    $error("ADPCM injection slot outside operator group 0");
  end

  localparam logic [4:0] LastSlot = 5'(SLOTS - 1);

  logic [4:0] slot_q, slot_d;
  logic       frame_done_q;
  logic       frame;
  logic [1:0] grp;
  logic [2:0] idx;
  op_e        op;

  assign frame = clk_en & (slot_q == LastSlot);

  // Slot counter advance with wrap at the end of the frame
  always_comb begin
    slot_d = slot_q;
    if (clk_en) slot_d = (slot_q == LastSlot) ? 5'd0 : slot_q + 5'd1;
  end

  // Slot counter and frame_done pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q       <= 5'd0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      frame_done_q <= frame;
    end
  end

  assign grp        = 2'(slot_q / 5'(CH_PER_GRP));
  assign idx        = 3'(slot_q % 5'(CH_PER_GRP));
  assign op         = op_order(grp);
  assign cur_ch     = ch_code(idx);
  assign cur_op     = grp;
  assign s1_enters  = (op == OpS1);
  assign s2_enters  = (op == OpS2);
  assign s3_enters  = (op == OpS3);
  assign s4_enters  = (op == OpS4);
  assign zero       = (slot_q == 5'd0);
  assign frame_done = frame_done_q;

  jt10_sample_hold #(
    .W      (W),
    .UCNT_W (UCNT_W)
  ) u_hold_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .mix_en   (mixA_en),
    .l_in     (adpcmA_l_in),
    .r_in     (adpcmA_r_in),
    .valid    (adpcmA_valid),
    .ready    (adpcmA_ready),
    .l        (adpcmA_l),
    .r        (adpcmA_r),
    .underrun (underrun_a)
  );

  jt10_sample_hold #(
    .W      (W),
    .UCNT_W (UCNT_W)
  ) u_hold_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .mix_en   (mixB_en),
    .l_in     (adpcmB_l_in),
    .r_in     (adpcmB_r_in),
    .valid    (adpcmB_valid),
    .ready    (adpcmB_ready),
    .l        (adpcmB_l),
    .r        (adpcmB_r),
    .underrun (underrun_b)
  );

endmodule

// File: tb/tb_jt10_mix_sched.sv
// Self-checking bench for jt10_mix_sched: directed scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_jt10_mix_sched;

  localparam int W      = 16;
  localparam int UCNT_W = 8;
  localparam int UMAX   = (1 << UCNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clk_en, mixA_en, mixB_en;
  logic [W-1:0]      adpcmA_l_in, adpcmA_r_in, adpcmB_l_in, adpcmB_r_in;
  logic              adpcmA_valid, adpcmB_valid, adpcmA_ready, adpcmB_ready;
  logic [2:0]        cur_ch;
  logic [1:0]        cur_op;
  logic              s1_enters, s2_enters, s3_enters, s4_enters, zero, frame_done;
  logic [W-1:0]      adpcmA_l, adpcmA_r, adpcmB_l, adpcmB_r;
  logic [UCNT_W-1:0] underrun_a, underrun_b;

  jt10_mix_sched #(.W(W), .UCNT_W(UCNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .mixA_en      (mixA_en),
    .mixB_en      (mixB_en),
    .adpcmA_l_in  (adpcmA_l_in),
    .adpcmA_r_in  (adpcmA_r_in),
    .adpcmA_valid (adpcmA_valid),
    .adpcmA_ready (adpcmA_ready),
    .adpcmB_l_in  (adpcmB_l_in),
    .adpcmB_r_in  (adpcmB_r_in),
    .adpcmB_valid (adpcmB_valid),
    .adpcmB_ready (adpcmB_ready),
    .cur_ch       (cur_ch),
    .cur_op       (cur_op),
    .s1_enters    (s1_enters),
    .s2_enters    (s2_enters),
    .s3_enters    (s3_enters),
    .s4_enters    (s4_enters),
    .zero         (zero),
    .adpcmA_l     (adpcmA_l),
    .adpcmA_r     (adpcmA_r),
    .adpcmB_l     (adpcmB_l),
    .adpcmB_r     (adpcmB_r),
    .frame_done   (frame_done),
    .underrun_a   (underrun_a),
    .underrun_b   (underrun_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = stream A, 1 = stream B
  int mslot;
  bit mpv[2];
  int mpl[2], mpr[2], mal[2], mar[2], mu[2];
  bit mfd;
  bit chk_en = 1'b0;
  int chs[6] = '{0, 1, 2, 4, 5, 6};
  int strobe_of_grp[4] = '{1, 3, 2, 4};

  function automatic bit m_frame();
    return clk_en && (mslot == 23);
  endfunction

  task automatic model_step();
    bit v[2];
    int li[2], ri[2];
    bit f, rdy;
    v[0] = adpcmA_valid; li[0] = adpcmA_l_in; ri[0] = adpcmA_r_in;
    v[1] = adpcmB_valid; li[1] = adpcmB_l_in; ri[1] = adpcmB_r_in;
    if (!rst_n) begin
      mslot = 0;
      mfd   = 0;
      for (int s = 0; s < 2; s++) begin
        mpv[s] = 0; mpl[s] = 0; mpr[s] = 0; mal[s] = 0; mar[s] = 0; mu[s] = 0;
      end
    end else begin
      f = m_frame();
      for (int s = 0; s < 2; s++) begin
        rdy = !mpv[s] || f;
        if (f) begin
          if (mpv[s]) begin
            mal[s] = mpl[s]; mar[s] = mpr[s];
            mpv[s] = v[s];
            if (v[s]) begin mpl[s] = li[s]; mpr[s] = ri[s]; end
          end else if (v[s]) begin
            mal[s] = li[s]; mar[s] = ri[s];
          end else begin
            mu[s] = (mu[s] < UMAX) ? mu[s] + 1 : UMAX;
          end
        end else if (v[s] && rdy) begin
          mpl[s] = li[s]; mpr[s] = ri[s]; mpv[s] = 1;
        end
      end
      mfd = f;
      if (clk_en) mslot = (mslot + 1) % 24;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic goto_slot(input int n);
    for (int i = 0; i < 50; i++) begin
      if (mslot == n) return;
      tick();
    end
    chk("goto_slot_timeout", 32'(mslot), 32'(n));
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      logic [3:0] exp_s;
      g = mslot / 6;
      exp_s = 4'b1000 >> (strobe_of_grp[g] - 1);
      chk("cur_ch", 32'(cur_ch), 32'(chs[mslot % 6]));
      chk("cur_op", 32'(cur_op), 32'(g));
      chk("strobes", 32'({s1_enters, s2_enters, s3_enters, s4_enters}), 32'(exp_s));
      chk("zero", 32'(zero), 32'(mslot == 0));
      chk("frame_done", 32'(frame_done), 32'(mfd));
      chk("readyA", 32'(adpcmA_ready), 32'(!mpv[0] || m_frame()));
      chk("readyB", 32'(adpcmB_ready), 32'(!mpv[1] || m_frame()));
      chk("adpcmA_l", 32'(adpcmA_l), mixA_en ? 32'(mal[0]) : 32'd0);
      chk("adpcmA_r", 32'(adpcmA_r), mixA_en ? 32'(mar[0]) : 32'd0);
      chk("adpcmB_l", 32'(adpcmB_l), mixB_en ? 32'(mal[1]) : 32'd0);
      chk("adpcmB_r", 32'(adpcmB_r), mixB_en ? 32'(mar[1]) : 32'd0);
      chk("underrun_a", 32'(underrun_a), 32'(mu[0]));
      chk("underrun_b", 32'(underrun_b), 32'(mu[1]));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ua;
    rst_n = 0; clk_en = 0; mixA_en = 1; mixB_en = 1;
    adpcmA_valid = 0; adpcmB_valid = 0;
    adpcmA_l_in = '0; adpcmA_r_in = '0; adpcmB_l_in = '0; adpcmB_r_in = '0;
    tick(); tick();
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);
    chk("rst_s1", 32'({s1_enters, s2_enters, s3_enters, s4_enters}), 32'b1000);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_readyA", 32'(adpcmA_ready), 32'd1);
    chk("rst_readyB", 32'(adpcmB_ready), 32'd1);
    chk("rst_adpcmA_l", 32'(adpcmA_l), 32'd0);
    chk("rst_underrun_b", 32'(underrun_b), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // B: one sample, then valid low for 3 more frames
    rst_n = 1; clk_en = 1;
    goto_slot(3);
    adpcmB_valid = 1; adpcmB_l_in = 16'h4321; adpcmB_r_in = 16'h1111;
    tick();
    adpcmB_valid = 0;
    chk("b_ready_full", 32'(adpcmB_ready), 32'd0);
    goto_slot(9);
    chk("slot9_ch", 32'(cur_ch), 32'd4);
    chk("slot9_op", 32'(cur_op), 32'd1);
    chk("slot9_s3", 32'(s3_enters), 32'd1);
    for (int f = 0; f < 4; f++) begin goto_slot(23); tick(); end
    chk("b_underrun3", 32'(underrun_b), 32'd3);
    chk("b_repeat_l", 32'(adpcmB_l), 32'h4321);
    chk("b_repeat_r", 32'(adpcmB_r), 32'h1111);
    for (int f = 0; f < 297; f++) begin goto_slot(23); tick(); end
    chk("b_underrun_sat", 32'(underrun_b), 32'd255);

    // A: mid-frame push appears at the frame boundary
    goto_slot(10);
    adpcmA_valid = 1; adpcmA_l_in = 16'h1234; adpcmA_r_in = 16'hEDCC;
    tick();
    adpcmA_valid = 0;
    chk("a_ready_low", 32'(adpcmA_ready), 32'd0);
    goto_slot(23); tick();
    chk("a_frame_l", 32'(adpcmA_l), 32'h1234);
    chk("a_frame_r", 32'(adpcmA_r), 32'hEDCC);
    chk("a_ready_back", 32'(adpcmA_ready), 32'd1);

    // A: pending full with a new sample landing exactly on the frame edge
    goto_slot(10);
    adpcmA_valid = 1; adpcmA_l_in = 16'h0101; adpcmA_r_in = 16'h0101;
    tick();
    adpcmA_valid = 0;
    goto_slot(23);
    ua = 32'(underrun_a);
    adpcmA_valid = 1; adpcmA_l_in = 16'h0202; adpcmA_r_in = 16'h0202;
    tick();
    adpcmA_valid = 0;
    chk("onF_active", 32'(adpcmA_l), 32'h0101);
    chk("onF_full", 32'(adpcmA_ready), 32'd0);
    chk("onF_no_underrun", 32'(underrun_a), 32'(ua));
    goto_slot(23); tick();
    chk("onF_next", 32'(adpcmA_l), 32'h0202);

    // A: bypass with empty pending
    goto_slot(23);
    ua = 32'(underrun_a);
    adpcmA_valid = 1; adpcmA_l_in = 16'h7FFF; adpcmA_r_in = 16'h7FFF;
    tick();
    adpcmA_valid = 0;
    chk("bypass_l", 32'(adpcmA_l), 32'h7FFF);
    chk("bypass_underrun", 32'(underrun_a), 32'(ua));
    chk("bypass_ready", 32'(adpcmA_ready), 32'd1);
    mixA_en = 0; #1;
    chk("mix_off", 32'(adpcmA_l), 32'd0);
    mixA_en = 1;

    // Random traffic, including clk_en gaps and occasional reset
    for (int i = 0; i < 3000; i++) begin
      clk_en       = ($urandom_range(0, 3) != 0);
      adpcmA_valid = ($urandom_range(0, 2) == 0);
      adpcmB_valid = ($urandom_range(0, 2) == 0);
      adpcmA_l_in  = W'($urandom); adpcmA_r_in = W'($urandom);
      adpcmB_l_in  = W'($urandom); adpcmB_r_in = W'($urandom);
      mixA_en      = ($urandom_range(0, 7) != 0);
      mixB_en      = ($urandom_range(0, 7) != 0);
      rst_n        = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1; clk_en = 1; mixA_en = 1; mixB_en = 1;
    adpcmA_valid = 0; adpcmB_valid = 0;

    // Reset at slot 13 with a pending sample
    goto_slot(23); tick();
    goto_slot(5);
    adpcmA_valid = 1; adpcmA_l_in = 16'h2222; adpcmA_r_in = 16'h2222;
    tick();
    adpcmA_valid = 0;
    goto_slot(13);
    chk("pre_rst_full", 32'(adpcmA_ready), 32'd0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_ch", 32'(cur_ch), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    chk("mid_rst_A", 32'(adpcmA_l), 32'd0);
    chk("mid_rst_B", 32'(adpcmB_r), 32'd0);
    chk("mid_rst_ready", 32'(adpcmA_ready), 32'd1);
    chk("mid_rst_fdone", 32'(frame_done), 32'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
